// File: rtl/tanh_sched_pkg.sv
// Shared configuration for the tanh LUT scheduler: default data format,
// LUT read latency and a constant-capable clog2 helper.
package tanh_sched_pkg;

    localparam int N_DEF       = 8;   // LUT address / result width
    localparam int Q_DEF       = 7;   // fractional bits of the Q format
    localparam int LUT_LATENCY = 1;   // cycles from lut_addr edge to capture edge

    // Ceiling log2, at least 1 so a requester index is never zero-width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tanh_lut_sched_rr_arbiter.sv
// Combinational round-robin arbiter: starting at i_ptr, the first eligible
// requester (searching upward with wrap) receives a one-hot grant.
module rr_arbiter
    import tanh_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDW-1:0]     i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDW-1:0]     o_idx
);

    int             w_pos;
    logic [IDW-1:0] w_sel;
    logic           w_found;

    // Rotating priority search; the first hit latches w_found so later hits are ignored.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_sel = IDW'(w_pos);
            if (!w_found && i_eligible[w_sel]) begin
                w_found        = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

endmodule

// File: rtl/tanh_lut_sched.sv
// Time-shares one registered tanh LUT among NUM_REQ neuron units. A granted
// address is registered onto lut_addr, the LUT answers on the following
// negedge, and the next posedge parks the answer in the requester's result
// slot until the requester acknowledges it.
module tanh_lut_sched
    import tanh_sched_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int Q       = Q_DEF,
    parameter int NUM_REQ = 4,
    localparam int IDW    = clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*N-1:0] req_addr,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [NUM_REQ*N-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]   rsp_ack,
    output logic [N-1:0]         lut_addr,
    input  logic [N-1:0]         lut_data,
    output logic                 busy
);

    logic [N-1:0]         r_lut_addr;
    logic                 r_s1_valid;
    logic [IDW-1:0]       r_s1_id;
    logic [IDW-1:0]       r_ptr;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [NUM_REQ*N-1:0] r_rsp_data;

    logic [NUM_REQ-1:0]   w_pending;
    logic [NUM_REQ-1:0]   w_eligible;
    logic [NUM_REQ-1:0]   w_grant;
    logic [IDW-1:0]       w_idx;
    logic                 w_accept;
    logic [N-1:0]         w_addr_sel;
    logic [IDW-1:0]       w_ptr_next;

    // Format and latency are fixed by the LUT; they are kept visible here
    // without influencing any logic.
    logic w_unused_cfg;
    assign w_unused_cfg = (Q >= 0) ^ (LUT_LATENCY == 1);

    // A requester with a lookup in flight or an unconsumed result may not
    // re-enter arbitration; nothing is granted while reset is held.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_pending[gi]  = (r_s1_valid && (r_s1_id == IDW'(gi))) || r_rsp_valid[gi];
        assign w_eligible[gi] = req_valid[gi] && !w_pending[gi] && !rst;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_idx      (w_idx)
    );

    assign w_accept   = |(w_grant & req_valid);
    assign w_addr_sel = req_addr[w_idx*N +: N];
    assign w_ptr_next = (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    // Stage 1: register the winner's address toward the LUT and advance the pointer past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lut_addr <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_ptr      <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_lut_addr <= w_addr_sel;
                r_s1_id    <= w_idx;
                r_ptr      <= w_ptr_next;
            end
        end
    end

    // Stage 2: capture the LUT answer into the owner's slot; acks clear only the valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_s1_valid && (r_s1_id == IDW'(i))) begin
                    r_rsp_valid[i]        <= 1'b1;
                    r_rsp_data[i*N +: N]  <= lut_data;
                end else if (rsp_ack[i]) begin
                    r_rsp_valid[i]        <= 1'b0;
                end
            end
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign lut_addr  = r_lut_addr;
    assign busy      = r_s1_valid | (|r_rsp_valid);

endmodule
